// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - instruction-type codes, opcode constants and opcode classifier for decode_stage
package decode_pkg;

  localparam int REG_IDX_W = 5;

  // Instruction-type codes consumed by the control module
  localparam logic [3:0] TYPE_INVALID = 4'd0;
  localparam logic [3:0] TYPE_R       = 4'd1;
  localparam logic [3:0] TYPE_I       = 4'd2;
  localparam logic [3:0] TYPE_I_MEM   = 4'd3;
  localparam logic [3:0] TYPE_S       = 4'd4;
  localparam logic [3:0] TYPE_B       = 4'd5;
  localparam logic [3:0] TYPE_U       = 4'd6;
  localparam logic [3:0] TYPE_J       = 4'd7;
  localparam logic [3:0] TYPE_R4      = 4'd8;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_MADD   = 7'b1000011;
  localparam logic [6:0] OP_MSUB   = 7'b1000111;
  localparam logic [6:0] OP_NMSUB  = 7'b1001011;
  localparam logic [6:0] OP_NMADD  = 7'b1001111;

  function automatic logic [3:0] classify(input logic [6:0] opcode);
    logic [3:0] t;
    case (opcode)
      OP_OP:                            t = TYPE_R;
      OP_IMM, OP_JALR:                  t = TYPE_I;
      OP_LOAD:                          t = TYPE_I_MEM;
      OP_STORE:                         t = TYPE_S;
      OP_BRANCH:                        t = TYPE_B;
      OP_LUI, OP_AUIPC:                 t = TYPE_U;
      OP_JAL:                           t = TYPE_J;
      OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD: t = TYPE_R4;
      default:                          t = TYPE_INVALID;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - combinational I/S/B/U/J immediate generator, sign-extended to WORD_SIZE
module imm_gen
  import decode_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [31:7]          i_instr_hi,
  input  logic [3:0]           i_type,
  output logic [WORD_SIZE-1:0] o_imm
);

  logic [31:0] w_imm32;
  logic        w_sign;

  assign w_sign = i_instr_hi[31];

  // Assemble the 32-bit immediate for the decoded format; R/R4/INVALID carry none
  always_comb begin
    w_imm32 = '0;
    case (i_type)
      TYPE_I, TYPE_I_MEM: w_imm32 = {{20{w_sign}}, i_instr_hi[31:20]};
      TYPE_S:             w_imm32 = {{20{w_sign}}, i_instr_hi[31:25], i_instr_hi[11:7]};
      TYPE_B:             w_imm32 = {{19{w_sign}}, i_instr_hi[31], i_instr_hi[7],
                                     i_instr_hi[30:25], i_instr_hi[11:8], 1'b0};
      TYPE_U:             w_imm32 = {i_instr_hi[31:12], 12'b0};
      TYPE_J:             w_imm32 = {{11{w_sign}}, i_instr_hi[31], i_instr_hi[19:12],
                                     i_instr_hi[20], i_instr_hi[30:21], 1'b0};
      default:            w_imm32 = '0;
    endcase
  end

  generate
    if (WORD_SIZE > 32) begin : g_ext
      assign o_imm = {{(WORD_SIZE-32){w_imm32[31]}}, w_imm32};
    end else begin : g_fit
      assign o_imm = w_imm32[WORD_SIZE-1:0];
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with RAW scoreboard; DECODE_WB_BYPASS_EN enables same-cycle writeback bypass
module decode_stage
  import decode_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           instruction_type,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [REG_IDX_W-1:0] out_rs1,
  output logic [REG_IDX_W-1:0] out_rs2,
  output logic [REG_IDX_W-1:0] out_rs3,
  output logic [WORD_SIZE-1:0] out_imm,
  output logic                 out_writes_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                 stall
);

  // Decode of the incoming word
  logic [3:0]           w_type;
  logic [REG_IDX_W-1:0] w_rd, w_rs1, w_rs2, w_rs3;
  logic [WORD_SIZE-1:0] w_imm;
  logic                 w_writes_rd;
  logic                 w_reads_rs1, w_reads_rs2, w_reads_rs3;

  // Hazard and handshake
  logic [NUM_REGS-1:0]  w_sb_eff;
  logic                 w_haz_rs1, w_haz_rs2, w_haz_rs3, w_hazard;
  logic                 w_in_ready, w_capture, w_consume;

  // Held decoded instruction and pending-write scoreboard
  logic                 r_out_valid;
  logic [3:0]           r_type;
  logic [REG_IDX_W-1:0] r_rd, r_rs1, r_rs2, r_rs3;
  logic [WORD_SIZE-1:0] r_imm;
  logic                 r_writes_rd;
  logic [NUM_REGS-1:0]  r_sb;

  assign w_type = classify(in_instr[6:0]);
  assign w_rd   = in_instr[11:7];
  assign w_rs1  = in_instr[19:15];
  assign w_rs2  = in_instr[24:20];
  assign w_rs3  = in_instr[31:27];

  imm_gen #(.WORD_SIZE(WORD_SIZE)) u_imm_gen (
    .i_instr_hi (in_instr[31:7]),
    .i_type     (w_type),
    .o_imm      (w_imm)
  );

  // Which source fields the decoded format actually reads
  always_comb begin
    w_reads_rs1 = 1'b0;
    w_reads_rs2 = 1'b0;
    w_reads_rs3 = 1'b0;
    case (w_type)
      TYPE_R, TYPE_S, TYPE_B: begin
        w_reads_rs1 = 1'b1;
        w_reads_rs2 = 1'b1;
      end
      TYPE_I, TYPE_I_MEM: w_reads_rs1 = 1'b1;
      TYPE_R4: begin
        w_reads_rs1 = 1'b1;
        w_reads_rs2 = 1'b1;
        w_reads_rs3 = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_writes_rd = (w_rd != '0) &&
                       ((w_type == TYPE_R) || (w_type == TYPE_I) || (w_type == TYPE_I_MEM) ||
                        (w_type == TYPE_U) || (w_type == TYPE_J) || (w_type == TYPE_R4));

`ifdef DECODE_WB_BYPASS_EN
  // A register retiring this cycle no longer counts as pending
  always_comb begin
    w_sb_eff = r_sb;
    if (wb_valid && (wb_rd != '0)) w_sb_eff[wb_rd] = 1'b0;
  end
`else
  assign w_sb_eff = r_sb;
`endif

  // The held instruction will set its rd once consumed, so it counts as pending too
  assign w_haz_rs1 = w_reads_rs1 && (w_rs1 != '0) &&
                     (w_sb_eff[w_rs1] || (r_out_valid && r_writes_rd && (r_rd == w_rs1)));
  assign w_haz_rs2 = w_reads_rs2 && (w_rs2 != '0) &&
                     (w_sb_eff[w_rs2] || (r_out_valid && r_writes_rd && (r_rd == w_rs2)));
  assign w_haz_rs3 = w_reads_rs3 && (w_rs3 != '0) &&
                     (w_sb_eff[w_rs3] || (r_out_valid && r_writes_rd && (r_rd == w_rs3)));
  assign w_hazard  = w_haz_rs1 || w_haz_rs2 || w_haz_rs3;

  assign w_in_ready = !w_hazard && (!r_out_valid || out_ready) && !flush;
  assign w_capture  = in_valid && w_in_ready;
  // A flushed entry is dropped, never retired into the scoreboard
  assign w_consume  = r_out_valid && out_ready && !flush;

  // Output register: load on capture, otherwise drop on consume or flush, else hold
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_type      <= TYPE_INVALID;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs3       <= '0;
      r_imm       <= '0;
      r_writes_rd <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_type      <= w_type;
      r_rd        <= w_rd;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rs3       <= w_rs3;
      r_imm       <= w_imm;
      r_writes_rd <= w_writes_rd;
    end else if (flush || w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Scoreboard: writeback clears, consume sets; the set is issued last so it wins a tie
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sb <= '0;
    end else begin
      if (wb_valid && (wb_rd != '0)) r_sb[wb_rd] <= 1'b0;
      if (w_consume && r_writes_rd) r_sb[r_rd] <= 1'b1;
    end
  end

  assign in_ready         = w_in_ready;
  assign stall            = in_valid && !w_in_ready && w_hazard;
  assign out_valid        = r_out_valid;
  assign instruction_type = r_type;
  assign out_rd           = r_rd;
  assign out_rs1          = r_rs1;
  assign out_rs2          = r_rs2;
  assign out_rs3          = r_rs3;
  assign out_imm          = r_imm;
  assign out_writes_rd    = r_writes_rd;

endmodule
